pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor. It is the next generation of the team's fixed 4-bit ripple adder, generalised to WIDTH bits. The carry chain is split into STAGE_BITS-wide ripple slices with a register between slices. A valid/ready handshake sits at both ends, so the block can be placed directly in a streaming datapath. It adds a subtract mode, carry/borrow-in, carry-out and signed-overflow outputs.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of STAGE_BITS.
- STAGE_BITS, 4: bits resolved per pipeline stage. STAGES = WIDTH/STAGE_BITS is also the latency in cycles.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat; forced to 0 while rst_n=0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0: A+B+cin; 1: A−B−cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB. For subtract, 0 means a borrow occurred.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operands: B' = b XOR {WIDTH{sub}}; C0 = cin XOR sub. Result = a + B' + C0, truncated to WIDTH. cout is the carry out of the MSB.
- Stage k (k = 0..STAGES−1) adds slice bits [k·STAGE_BITS +: STAGE_BITS] of A and B', using the carry registered by stage k−1 (C0 for stage 0).
- Each stage register holds:
  - the stage valid bit,
  - the sum bits computed so far,
  - the untouched high slices of A and B',
  - the outgoing carry.
- The last stage also registers the carry into the MSB, for overflow.
- Global advance: adv = !out_valid | out_ready.
  - When adv=1, every stage register loads from its predecessor.
  - Stage 0 loads {in_valid, inputs}.
  - When adv=0, all registers hold.
- in_ready = rst_n & adv. This is combinational from out_valid and out_ready, by design.
- A beat transfers on input when in_valid & in_ready, and on output when out_valid & out_ready.
- Bubbles are not collapsed; an empty stage still waits for adv.
- Results emerge in acceptance order, with no loss or duplication.
- Data registers may hold stale values while their valid bit is 0. sum, cout and overflow are meaningful only while out_valid=1.

## Timing
- Reset (rst_n=0 at an edge): all stage valid bits clear, so out_valid=0 on the next cycle. sum=0, cout=0, overflow=0. in_ready=0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-operation discards every in-flight beat; none appears at the output.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles, provided adv stayed 1.
- Each cycle adv=0 adds one cycle of latency to every beat in flight.
- Throughput: one beat per cycle while out_ready=1.
- out_valid=1 with out_ready=0:
  - sum, cout and overflow hold stable,
  - in_ready=0,
  - the pipeline is frozen.
- Simultaneous input accept and output accept in the same cycle is legal and is the steady state.
- STAGE_BITS == WIDTH is a legal single-stage configuration with 1-cycle latency.

## Structure
- Shared package adder_pkg:
  - default WIDTH and STAGE_BITS,
  - a function computing STAGES,
  - a stage-register record typedef (valid, partial sum, carry, remaining operands).
- One sub-module, adder_slice: a combinational STAGE_BITS-wide ripple slice built from the team's full adder. It has ports a, b, ci, s, co, plus the carry into its MSB for overflow.
- The top level instantiates STAGES slices and the pipeline registers in a generate loop, and includes an elaboration-time check that WIDTH % STAGE_BITS == 0.

## Test plan
All scenarios use WIDTH=16 and STAGE_BITS=4 (latency 4) unless stated.
- Basic add: a=0x00FF, b=0x0001, cin=0, sub=0 → sum=0x0100, cout=0, overflow=0, out_valid exactly 4 cycles after accept.
- Carry and overflow:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, overflow=0.
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, overflow=1.
  - cin=1 with 0x0000+0x0000 → sum=0x0001.
- Subtract:
  - 0x0005−0x0007 → sum=0xFFFE, cout=0, overflow=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, overflow=1.
  - sub=1, cin=1, 0x0010−0x0001 → sum=0x000E.
- Backpressure: stream 8 back-to-back beats and hold out_ready=0 for 5 cycles after the 2nd result. Required:
  - outputs stable and in_ready=0 during the stall,
  - after release, all 8 results in order, none lost or duplicated.
- Reset mid-flight: 3 beats accepted, rst_n=0 for one edge → out_valid=0 next cycle, none of the 3 beats ever emerges, in_ready=1 after release.
- Parameter sweep: WIDTH=16 with STAGE_BITS=16 (latency 1), and WIDTH=32 with STAGE_BITS=8 (latency 4). Run 1000 random beats with random out_ready, scoreboarded against a behavioural a ± b ± cin model.

Source files
------------

// File: rtl/adder_pkg.sv
// ============================================================================
// Module  : adder_pkg
// Brief   : Shared defaults, stage-count helper, full adder and stage record
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_STAGE_BITS = 4;

    function automatic int num_stages(input int width, input int stage_bits);
        return width / stage_bits;
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    // Stage-register layout at the default width; the top level declares the
    // same record sized by its own parameters.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] opa;
        logic [DEF_WIDTH-1:0] opb;
        logic                 carry;
    } stage_reg_t;

endpackage

`default_nettype wire

// File: rtl/adder_slice.sv
// ============================================================================
// Module  : adder_slice
// Brief   : Combinational STAGE_BITS-wide ripple slice of full adders
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module adder_slice
    import adder_pkg::*;
#(
    parameter int STAGE_BITS = DEF_STAGE_BITS
) (
    input  logic [STAGE_BITS-1:0] a,
    input  logic [STAGE_BITS-1:0] b,
    input  logic                  ci,
    output logic [STAGE_BITS-1:0] s,
    output logic                  co,
    output logic                  cm
);

    logic w_carry;

    // cm is the carry entering the slice MSB, used for signed overflow.
    always_comb begin
        w_carry = ci;
        cm      = ci;
        s       = '0;
        for (int i = 0; i < STAGE_BITS; i++) begin
            if (i == STAGE_BITS - 1) begin
                cm = w_carry;
            end
            {w_carry, s[i]} = full_add(a[i], b[i], w_carry);
        end
        co = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// Module  : pipelined_adder
// Brief   : Pipelined add/subtract with valid/ready at both ends
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int STAGE_BITS = DEF_STAGE_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STAGES = num_stages(WIDTH, STAGE_BITS);

    if ((STAGE_BITS <= 0) || (WIDTH % STAGE_BITS != 0)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGE_BITS");
    end

    // Partial sum fills from the top; operands shift down so that bits
    // [STAGE_BITS-1:0] are always the next slice to resolve.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic             carry;
    } stage_t;

    stage_t w_stage [STAGES+1];
    logic   w_adv;
    logic   w_msb_carry;

    assign w_adv    = !w_stage[STAGES].valid || out_ready;
    assign in_ready = rst_n & w_adv;

    assign w_stage[0] = '{valid: in_valid,
                          sum:   '0,
                          opa:   a,
                          opb:   b ^ {WIDTH{sub}},
                          carry: cin ^ sub};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [STAGE_BITS-1:0] w_s;
        logic                  w_co;
        logic                  w_cm;
        stage_t                r_stage;

        adder_slice #(
            .STAGE_BITS (STAGE_BITS)
        ) u_slice (
            .a  (w_stage[k].opa[STAGE_BITS-1:0]),
            .b  (w_stage[k].opb[STAGE_BITS-1:0]),
            .ci (w_stage[k].carry),
            .s  (w_s),
            .co (w_co),
            .cm (w_cm)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_stage <= '0;
            end else if (w_adv) begin
                r_stage.valid <= w_stage[k].valid;
                r_stage.sum   <= (w_stage[k].sum >> STAGE_BITS)
                               | (WIDTH'(w_s) << (WIDTH - STAGE_BITS));
                r_stage.opa   <= w_stage[k].opa >> STAGE_BITS;
                r_stage.opb   <= w_stage[k].opb >> STAGE_BITS;
                r_stage.carry <= w_co;
            end
        end

        assign w_stage[k+1] = r_stage;

        if (k == STAGES - 1) begin : g_last
            logic r_msb_carry;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_msb_carry <= 1'b0;
                end else if (w_adv) begin
                    r_msb_carry <= w_cm;
                end
            end

            assign w_msb_carry = r_msb_carry;
        end
    end

    assign out_valid = w_stage[STAGES].valid;
    assign sum       = w_stage[STAGES].sum;
    assign cout      = w_stage[STAGES].carry;
    assign overflow  = w_stage[STAGES].carry ^ w_msb_carry;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// Module  : tb_pipelined_adder
// Brief   : Scoreboarded bench for three pipelined_adder configurations
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, cin, sub, out_ready;
    logic [31:0] a, b;

    logic        rdy0, ov0, co0, of0;
    logic [15:0] s0;
    logic        rdy1, ov1, co1, of1;
    logic [15:0] s1;
    logic        rdy2, ov2, co2, of2;
    logic [31:0] s2;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGE_BITS(4)) u_dut16x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .overflow(of0));

    pipelined_adder #(.WIDTH(16), .STAGE_BITS(16)) u_dut16x16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .overflow(of1));

    pipelined_adder #(.WIDTH(32), .STAGE_BITS(8)) u_dut32x8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .overflow(of2));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural reference: a +/- b +/- cin evaluated as wide integers.
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic s);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint ux = longint'(x) % m;
        longint uy = longint'(y) % m;
        longint sx = (ux >= m / 2) ? ux - m : ux;
        longint sy = (uy >= m / 2) ? uy - m : uy;
        longint lc = longint'(c);
        longint ru = s ? (ux - uy - lc) : (ux + uy + lc);
        longint rs = s ? (sx - sy - lc) : (sx + sy + lc);
        e.sum  = 32'(ru & (m - 1));
        e.cout = s ? (ru >= 0) : (ru >= m);
        e.ovf  = (rs < -(m / 2)) || (rs >= m / 2);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic rdy, output logic ov,
                          output logic [31:0] s, output logic co, output logic of);
        case (sel)
            0:       begin rdy = rdy0; ov = ov0; s = {16'h0, s0}; co = co0; of = of0; end
            1:       begin rdy = rdy1; ov = ov1; s = {16'h0, s1}; co = co1; of = of1; end
            default: begin rdy = rdy2; ov = ov2; s = s2;          co = co2; of = of2; end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({ov0, s0, co0, of0} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got ov=%b sum=%h cout=%b ovf=%b, expected all zero",
                     ov0, s0, co0, of0);
        end
        n_vec++;
        if (rdy0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready_low: got %b, expected 0", rdy0);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (rdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready_release: got %b, expected 1", rdy0);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] va [7] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005, 16'h8000, 16'h0010};
        logic [15:0] vb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
        logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] es [7] = '{16'h0100, 16'h0000, 16'h8000, 16'h0001, 16'hFFFE, 16'h7FFF, 16'h000E};
        logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = {16'h0, va[i]}; b = {16'h0, vb[i]}; cin = vc[i]; sub = vs[i];
            in_valid = 1'b1;
            #1;
            n_vec++;
            if (rdy0 !== 1'b1) begin
                n_err++;
                $display("FAIL directed_in_ready[%0d]: got %b, expected 1", i, rdy0);
            end
            sb.push_back('{sum: {16'h0, es[i]}, cout: ec[i], ovf: eo[i]});
            lat = 0;
            do begin
                tick();
                in_valid = 1'b0;
                lat++;
            end while (!ov0 && lat < 20);
            n_vec++;
            if (lat !== 4) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, expected 4", i, lat);
            end
            if (ov0 && sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({s0, co0, of0} !== {e.sum[15:0], e.cout, e.ovf}) begin
                    n_err++;
                    $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                             i, s0, co0, of0, e.sum[15:0], e.cout, e.ovf);
                end
            end
        end
        tick();
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          sent = 0, got = 0, stall = 0, cyc = 0;
        logic [15:0] hold_s;
        logic        hold_c, hold_o;
        while (got < 8 && cyc < 100) begin
            in_valid  = (sent < 8);
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                n_vec++;
                if (stall == 5) begin
                    hold_s = s0; hold_c = co0; hold_o = of0;
                    if (ov0 !== 1'b1 || rdy0 !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_entry: got ov=%b in_ready=%b, expected ov=1 in_ready=0", ov0, rdy0);
                    end
                end else if ({ov0, rdy0, s0, co0, of0} !== {2'b10, hold_s, hold_c, hold_o}) begin
                    n_err++;
                    $display("FAIL stall_stable: got ov=%b in_ready=%b sum=%h cout=%b ovf=%b, expected ov=1 in_ready=0 sum=%h cout=%b ovf=%b",
                             ov0, rdy0, s0, co0, of0, hold_s, hold_c, hold_o);
                end
                stall--;
            end
            if (ov0 && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra_output: got sum=%h, expected no output", s0);
                end else begin
                    e = sb.pop_front();
                    if ({s0, co0, of0} !== {e.sum[15:0], e.cout, e.ovf}) begin
                        n_err++;
                        $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 got, s0, co0, of0, e.sum[15:0], e.cout, e.ovf);
                    end
                end
                got++;
                if (got == 2) stall = 5;
            end
            if (in_valid && rdy0) begin
                sb.push_back(model(16, a, b, cin, sub));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (got !== 8 || sent !== 8 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results (%0d sent, %0d pending), expected 8/8/0",
                     got, sent, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'h100 * (i + 1); b = 32'h3; cin = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        n_vec++;
        if (ov0 !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_out_valid: got %b, expected 0", ov0);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (rdy0 !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_in_ready: got %b, expected 1", rdy0);
        end
        repeat (8) begin
            tick();
            if (ov0 !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midflight_discard: got a discarded beat at output, expected none");
        end
    endtask

    task automatic test_sweep(input int sel, input int w);
        exp_t        e;
        logic        rdy, ov, co, of;
        logic [31:0] s;
        int          sent = 0, cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        while ((sent < 1000 || sb.size() > 0) && cyc < 6000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = (sent >= 1000) || ($urandom_range(0, 3) != 0);
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            #1;
            sample(sel, rdy, ov, s, co, of);
            if (ov && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sweep%0d_extra_output: got sum=%h, expected no output", sel, s);
                end else begin
                    e = sb.pop_front();
                    if ({s, co, of} !== {e.sum, e.cout, e.ovf}) begin
                        n_err++;
                        $display("FAIL sweep%0d_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 sel, s, co, of, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && rdy) begin
                sb.push_back(model(w, a, b, cin, sub));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (sent !== 1000 || sb.size() !== 0) begin
            n_err++;
            $display("FAIL sweep%0d_drain: got %0d sent, %0d pending, expected 1000 sent, 0 pending",
                     sel, sent, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_sweep(1, 16);
        test_sweep(2, 32);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
